// File: rtl/router_packet_tx_if.sv
// router_packet_tx_if: FIFO dequeue side plus valid/ready flit link for router_packet_tx.
//   fifo_d_out/fifo_empty_n/fifo_deq : BSV-style FIFO dequeue port
//   tx_data/tx_valid/tx_ready        : flit handshake toward the router port
//   tx_first/tx_last/tx_dest         : packet framing sideband
// master = transmitter view, slave = environment (FIFO + link) view.
interface router_packet_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]           fifo_d_out;
    logic                            fifo_empty_n;
    logic                            fifo_deq;
    logic [DATA_WIDTH-1:0]           tx_data;
    logic                            tx_valid;
    logic                            tx_ready;
    logic                            tx_first;
    logic                            tx_last;
    logic [DATA_WIDTH-LEN_WIDTH-1:0] tx_dest;

    modport master (
        input  fifo_d_out, fifo_empty_n, tx_ready,
        output fifo_deq, tx_data, tx_valid, tx_first, tx_last, tx_dest
    );

    modport slave (
        output fifo_d_out, fifo_empty_n, tx_ready,
        input  fifo_deq, tx_data, tx_valid, tx_first, tx_last, tx_dest
    );
endinterface

// File: rtl/router_packet_tx.sv
// router_packet_tx: drains the router FIFO and emits framed packets as flits.
//   clk, reset (sync, active-high), clr (sync flush)
//   bus       : router_packet_tx_if.master (FIFO dequeue side + flit link)
//   busy      : header dequeued, last flit not yet accepted
//   pkt_count : packets fully transmitted, wraps
module router_packet_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    router_packet_tx_if.master    bus,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_count
);
    localparam int DEST_WIDTH = DATA_WIDTH - LEN_WIDTH;

    typedef enum logic {HDR, PAY} state_t;

    state_t                state, state_n;
    logic [LEN_WIDTH-1:0]  remaining, remaining_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [DEST_WIDTH-1:0] dest_n;
    logic [CNT_WIDTH-1:0]  count_n;
    logic                  valid_n, first_n, last_n, busy_n;
    logic                  ld, acc;

    assign acc          = bus.tx_valid && bus.tx_ready;
    assign ld           = bus.fifo_empty_n && (!bus.tx_valid || bus.tx_ready) && !clr && !reset;
    assign bus.fifo_deq = ld;

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        data_n      = bus.tx_data;
        dest_n      = bus.tx_dest;
        valid_n     = bus.tx_valid && !acc;
        first_n     = bus.tx_first;
        last_n      = bus.tx_last;
        busy_n      = busy;
        count_n     = pkt_count;
        if (acc && bus.tx_last) begin
            busy_n  = 1'b0;
            count_n = pkt_count + 1'b1;
        end
        if (ld) begin
            valid_n = 1'b1;
            data_n  = bus.fifo_d_out;
            if (state == HDR) begin
                dest_n      = bus.fifo_d_out[DATA_WIDTH-1:LEN_WIDTH];
                remaining_n = bus.fifo_d_out[LEN_WIDTH-1:0];
                first_n     = 1'b1;
                last_n      = bus.fifo_d_out[LEN_WIDTH-1:0] == '0;
                busy_n      = 1'b1;
                state_n     = bus.fifo_d_out[LEN_WIDTH-1:0] == '0 ? HDR : PAY;
            end else begin
                remaining_n = remaining - 1'b1;
                first_n     = 1'b0;
                last_n      = remaining == LEN_WIDTH'(1);
                state_n     = remaining == LEN_WIDTH'(1) ? HDR : PAY;
            end
        end
        // A flush drops the register but never credits a packet, even one whose last flit is leaving now.
        if (clr) begin
            state_n     = HDR;
            remaining_n = '0;
            valid_n     = 1'b0;
            first_n     = 1'b0;
            last_n      = 1'b0;
            busy_n      = 1'b0;
            count_n     = pkt_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HDR;
            remaining    <= '0;
            bus.tx_data  <= '0;
            bus.tx_dest  <= '0;
            bus.tx_valid <= 1'b0;
            bus.tx_first <= 1'b0;
            bus.tx_last  <= 1'b0;
            busy         <= 1'b0;
            pkt_count    <= '0;
        end else begin
            state        <= state_n;
            remaining    <= remaining_n;
            bus.tx_data  <= data_n;
            bus.tx_dest  <= dest_n;
            bus.tx_valid <= valid_n;
            bus.tx_first <= first_n;
            bus.tx_last  <= last_n;
            busy         <= busy_n;
            pkt_count    <= count_n;
        end
    end
endmodule

// File: tb/tb_router_packet_tx.sv
// tb_router_packet_tx: directed self-checking bench for router_packet_tx with a queue-modelled FIFO.
module tb_router_packet_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        busy;
    logic [15:0] pkt_count;

    router_packet_tx_if #(.DATA_WIDTH(8), .LEN_WIDTH(4)) bus();

    router_packet_tx #(.DATA_WIDTH(8), .LEN_WIDTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .clr(clr), .bus(bus), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    logic [7:0]  q[$];
    logic [7:0]  acc_log[$];
    int          tests = 0;
    int          fails = 0;
    int          pops = 0;
    int          accs = 0;
    logic        deq_seen;
    logic [15:0] exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: present FIFO head at negedge, observe deq/acceptance, then settle after posedge.
    task automatic tick();
        @(negedge clk);
        bus.fifo_empty_n = q.size() != 0;
        bus.fifo_d_out   = q.size() != 0 ? q[0] : 8'h00;
        #1;
        deq_seen = bus.fifo_deq;
        if (bus.tx_valid && bus.tx_ready) begin
            accs++;
            acc_log.push_back(bus.tx_data);
            if (bus.tx_last && !clr && !reset) exp_cnt++;
        end
        if (deq_seen && q.size() != 0) begin
            void'(q.pop_front());
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flit(input string tag, input logic [7:0] d, input logic f, input logic l, input logic [3:0] dest);
        check({tag, ".valid"}, bus.tx_valid, 1);
        check({tag, ".data"}, bus.tx_data, d);
        check({tag, ".first"}, bus.tx_first, f);
        check({tag, ".last"}, bus.tx_last, l);
        check({tag, ".dest"}, bus.tx_dest, dest);
        check({tag, ".busy"}, busy, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] rdy_pat;
        logic [9:0] deq_pat;
        logic [7:0] dat[9];
        int         p0;
        int         a0;
        logic [15:0] c0;
        bus.tx_ready     = 1'b1;
        bus.fifo_empty_n = 1'b0;
        bus.fifo_d_out   = 8'h00;
        q.push_back(8'h53);
        tick();
        check("rst.deq", deq_seen, 0);
        tick();
        check("rst.valid", bus.tx_valid, 0);
        check("rst.first", bus.tx_first, 0);
        check("rst.last", bus.tx_last, 0);
        check("rst.data", bus.tx_data, 0);
        check("rst.dest", bus.tx_dest, 0);
        check("rst.busy", busy, 0);
        check("rst.cnt", pkt_count, 0);
        reset = 1'b0;
        q.delete();

        // 4-flit packet at full rate
        q = '{8'h53, 8'hA1, 8'hA2, 8'hA3};
        tick(); flit("p1.f0", 8'h53, 1, 0, 5);
        tick(); flit("p1.f1", 8'hA1, 0, 0, 5);
        tick(); flit("p1.f2", 8'hA2, 0, 0, 5);
        tick(); flit("p1.f3", 8'hA3, 0, 1, 5);
        check("p1.cnt_before", pkt_count, 0);
        tick();
        check("p1.idle_valid", bus.tx_valid, 0);
        check("p1.idle_busy", busy, 0);
        check("p1.cnt", pkt_count, 1);

        // header-only packet then 2-flit packet, back to back
        q = '{8'h70, 8'h21, 8'hEE};
        tick(); flit("p2.h0", 8'h70, 1, 1, 7);
        tick(); flit("p2.h1", 8'h21, 1, 0, 2);
        check("p2.cnt_mid", pkt_count, 2);
        tick(); flit("p2.p1", 8'hEE, 0, 1, 2);
        tick();
        check("p2.idle_valid", bus.tx_valid, 0);
        check("p2.idle_busy", busy, 0);
        check("p2.cnt", pkt_count, 3);

        // backpressure pattern
        rdy_pat = 10'b1010101001;
        deq_pat = 10'b0010101001;
        dat = '{8'h53, 8'h53, 8'h53, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA3, 8'hA3};
        p0 = pops;
        a0 = accs;
        acc_log.delete();
        q = '{8'h53, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 10; i++) begin
            bus.tx_ready = rdy_pat[i];
            tick();
            check($sformatf("bp.deq%0d", i), deq_seen, deq_pat[i]);
            if (i < 9) check($sformatf("bp.data%0d", i), bus.tx_data, dat[i]);
        end
        check("bp.idle_valid", bus.tx_valid, 0);
        check("bp.pops", pops - p0, 4);
        check("bp.accs", accs - a0, 4);
        check("bp.log_size", acc_log.size(), 4);
        if (acc_log.size() == 4)
            check("bp.order", {acc_log[0], acc_log[1], acc_log[2], acc_log[3]}, 32'h53A1A2A3);
        check("bp.cnt", pkt_count, 4);

        // FIFO underrun mid-packet
        bus.tx_ready = 1'b1;
        q = '{8'h32, 8'hB1};
        tick(); flit("gap.h", 8'h32, 1, 0, 3);
        tick(); flit("gap.p1", 8'hB1, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gap.valid%0d", i), bus.tx_valid, 0);
            check($sformatf("gap.busy%0d", i), busy, 1);
            check($sformatf("gap.dest%0d", i), bus.tx_dest, 3);
        end
        q.push_back(8'hB2);
        tick(); flit("gap.p2", 8'hB2, 0, 1, 3);
        tick();
        check("gap.busy_end", busy, 0);
        check("gap.cnt", pkt_count, 5);

        // clr mid-packet
        q = '{8'h63, 8'hC1, 8'hC2};
        tick(); tick(); tick();
        check("clr.pre_data", bus.tx_data, 8'hC2);
        q.push_back(8'h10);
        c0 = pkt_count;
        clr = 1'b1;
        tick();
        check("clr.deq", deq_seen, 0);
        check("clr.valid", bus.tx_valid, 0);
        check("clr.busy", busy, 0);
        check("clr.first", bus.tx_first, 0);
        check("clr.last", bus.tx_last, 0);
        check("clr.cnt", pkt_count, c0);
        clr = 1'b0;
        tick(); flit("clr.hdr", 8'h10, 1, 1, 1);
        clr = 1'b1;
        tick();
        check("clr.last_acc_cnt", pkt_count, c0);
        check("clr.last_acc_valid", bus.tx_valid, 0);
        clr = 1'b0;

        // reset mid-packet
        check("rst2.cnt_pre", pkt_count, 5);
        q = '{8'h53, 8'hA1, 8'hA2, 8'hA3};
        tick(); tick();
        check("rst2.pre_data", bus.tx_data, 8'hA1);
        reset = 1'b1;
        tick();
        check("rst2.deq", deq_seen, 0);
        check("rst2.valid", bus.tx_valid, 0);
        check("rst2.first", bus.tx_first, 0);
        check("rst2.last", bus.tx_last, 0);
        check("rst2.data", bus.tx_data, 0);
        check("rst2.dest", bus.tx_dest, 0);
        check("rst2.busy", busy, 0);
        check("rst2.cnt", pkt_count, 0);
        reset = 1'b0;
        exp_cnt = 0;
        q.delete();
        q.push_back(8'h70);
        tick(); flit("rst2.hdr", 8'h70, 1, 1, 7);
        tick();
        check("rst2.cnt_after", pkt_count, 1);
        check("rst2.model_cnt", pkt_count, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
